// File: rtl/axis_sample_fifo.sv
// First-word-fall-through sample FIFO with drop-on-full overflow pulse.
// Optional saturating drop counter enabled by `AXIS_SAMPLE_FIFO_OVF_CNT_EN.
module axis_sample_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic [15:0]           overflow_count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ZERO_LEVEL = (DEPTH_LOG2 + 1)'(0);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   level_r;
    logic [DEPTH_LOG2:0]   level_nxt_s;
    logic                  tvalid_r;
    logic                  overflow_r;
    logic                  rd_en_s;
    logic                  wr_en_s;
    logic                  drop_s;
    logic                  full_s;

    // Handshake decode: a read frees a slot, so a full FIFO still accepts a write alongside it.
    always_comb begin
        rd_en_s     = 1'b0;
        wr_en_s     = 1'b0;
        drop_s      = 1'b0;
        full_s      = 1'b0;
        level_nxt_s = level_r;
        full_s      = (level_r == FULL_LEVEL);
        rd_en_s     = tvalid_r & m_axis_tready;
        wr_en_s     = s_axis_tvalid & (~full_s | rd_en_s);
        drop_s      = s_axis_tvalid & full_s & ~rd_en_s;
        case ({wr_en_s, rd_en_s})
            2'b10:   level_nxt_s = level_r + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_nxt_s = level_r - (DEPTH_LOG2 + 1)'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Pointers, occupancy, head-valid flag and overflow pulse.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            tvalid_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
            end
            level_r    <= level_nxt_s;
            tvalid_r   <= (level_nxt_s != ZERO_LEVEL);
            overflow_r <= drop_s;
        end
    end

    // Sample storage is deliberately left unreset; contents are only visible while valid.
    always_ff @(posedge s_axis_aclk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= s_axis_tdata;
        end
    end

`ifdef AXIS_SAMPLE_FIFO_OVF_CNT_EN
    logic [15:0] ovf_cnt_r;

    // Saturating drop counter; a clear wins over a coincident drop.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            ovf_cnt_r <= 16'h0000;
        end else if (clr_overflow) begin
            ovf_cnt_r <= 16'h0000;
        end else if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 16'h0001;
        end
    end

    assign overflow_count = ovf_cnt_r;
`else
    logic clr_overflow_unused_s;

    assign clr_overflow_unused_s = clr_overflow;
    assign overflow_count        = 16'h0000;
`endif

    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = mem_r[rd_ptr_r];
    assign fifo_level    = level_r;
    assign overflow      = overflow_r;

endmodule

// File: tb/tb_axis_sample_fifo.sv
// Directed + random bench for axis_sample_fifo against a queue-based reference model.
// Expected overflow_count follows `AXIS_SAMPLE_FIFO_OVF_CNT_EN when defined.
module tb_axis_sample_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [4:0]    level;
    logic          ovf;
    logic          clr;
    logic [15:0]   ovf_cnt;

    int            n_checks;
    int            n_fails;
    logic [DW-1:0] q [$];
    logic          exp_ovf;
    logic [15:0]   exp_cnt;

    axis_sample_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(4)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .s_axis_tvalid  (s_valid),
        .s_axis_tdata   (s_data),
        .m_axis_tvalid  (m_valid),
        .m_axis_tready  (m_ready),
        .m_axis_tdata   (m_data),
        .fifo_level     (level),
        .overflow       (ovf),
        .clr_overflow   (clr),
        .overflow_count (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("tvalid", 64'(m_valid), 64'(q.size() != 0));
        if (q.size() != 0) chk("tdata", 64'(m_data), 64'(q[0]));
        chk("level", 64'(level), 64'(q.size()));
        chk("overflow", 64'(ovf), 64'(exp_ovf));
        chk("ovf_cnt", 64'(ovf_cnt), 64'(exp_cnt));
    endtask

    // One clock: check state at the falling edge, drive inputs, advance the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
        logic rd;
        logic wr;
        logic drop;
        @(negedge clk);
        check_outputs();
        s_valid = v;
        s_data  = d;
        m_ready = r;
        clr     = c;
        rd   = (q.size() != 0) && r;
        wr   = v && ((q.size() < DEPTH) || rd);
        drop = v && !wr;
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(d);
        exp_ovf = drop;
`ifdef AXIS_SAMPLE_FIFO_OVF_CNT_EN
        if (c) exp_cnt = 16'h0000;
        else if (drop && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h0001;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        exp_ovf  = 1'b0;
        exp_cnt  = 16'h0000;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 32'h0;
        m_ready  = 1'b0;
        clr      = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 1..16 while stalled, then drain in order.
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_level", 64'(level), 64'd16);
        for (int i = 0; i < 17; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Single write into an empty FIFO: visible only after the edge.
        step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        chk("lat_not_before", 64'(m_valid), 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("lat_data", 64'(m_data), 64'hA5A5_A5A5);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill, then three drops while stalled.
        for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Full FIFO streaming with simultaneous read and write.
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1, 1'b0);

        // clr_overflow (ignored when the counter is compiled out).
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Reset mid-operation with 5 words buffered, asserted between edges.
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_tvalid", 64'(m_valid), 64'd0);
        #1 rst_n = 1'b1;
        q.delete();
        exp_ovf = 1'b0;
        exp_cnt = 16'h0000;
        step(1'b1, 32'h0000_0042, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0043, 1'b0, 1'b0);
        chk("post_rst_first", 64'(m_data), 64'h42);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 99) < 3));
        for (int i = 0; i < 18; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef AXIS_SAMPLE_FIFO_OVF_CNT_EN
        // Saturation after 65540 drops, then clear coinciding with a drop.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ovf_sat", 64'(ovf_cnt), 64'hFFFF);
        step(1'b1, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ovf_clr_drop", 64'(ovf_cnt), 64'h0);
`endif
        step(1'b0, 32'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axis_sample_fifo.md
AXIS_SAMPLE_FIFO -- requirements
Module: axis_sample_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the sample word width in bits.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 4, so that the FIFO depth is DEPTH = 2**DEPTH_LOG2 words.
REQ-003 Port s_axis_aclk SHALL be input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port s_axis_aresetn SHALL be input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port s_axis_tvalid SHALL be input, 1 bit: sample valid from the upstream switch mux; there is no upstream backpressure.
REQ-006 Port s_axis_tdata SHALL be input, DATA_WIDTH bits: sample data from the upstream switch mux.
REQ-007 Port m_axis_tvalid SHALL be output, 1 bit: the head word is available.
REQ-008 Port m_axis_tready SHALL be input, 1 bit: the downstream consumer accepts the head word.
REQ-009 Port m_axis_tdata SHALL be output, DATA_WIDTH bits: the head word.
REQ-010 Port fifo_level SHALL be output, DEPTH_LOG2+1 bits: occupancy, range 0..DEPTH.
REQ-011 Port overflow SHALL be output, 1 bit: one-cycle pulse when an input sample is dropped.
REQ-012 Port clr_overflow SHALL be input, 1 bit: synchronous clear of overflow_count.
REQ-013 Port overflow_count SHALL be output, 16 bits: count of dropped samples.

Function
REQ-014 A write SHALL occur when s_axis_tvalid=1 and either fifo_level<DEPTH or a read occurs in the same cycle.
REQ-015 A read SHALL occur when m_axis_tvalid=1 and m_axis_tready=1.
REQ-016 m_axis_tvalid SHALL equal (fifo_level!=0), and m_axis_tdata SHALL be the word at the read pointer (first-word-fall-through).
REQ-017 Latency SHALL be one cycle: a word written at edge N into an empty FIFO appears with m_axis_tvalid=1 after edge N; there is no same-cycle bypass.
REQ-018 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata SHALL remain stable.
REQ-019 Simultaneous read and write SHALL leave fifo_level unchanged, including when the FIFO is full (the write is accepted) and when the level is 1.
REQ-020 Read and write pointers SHALL be DEPTH_LOG2 bits wide and wrap modulo DEPTH.
REQ-021 fifo_level SHALL increment on a write without a read, decrement on a read without a write, and otherwise hold.
REQ-022 A sample with s_axis_tvalid=1 arriving when fifo_level=DEPTH and no read occurs SHALL be dropped (FIFO contents unchanged), and overflow SHALL be 1 for the following cycle only.
REQ-023 Data order SHALL be strictly preserved; no word is duplicated or lost except dropped samples under REQ-022.
REQ-024 s_axis_tdata SHALL be ignored when s_axis_tvalid=0.

Reset
REQ-025 Asserting s_axis_aresetn low SHALL immediately clear the read/write pointers, fifo_level, m_axis_tvalid, overflow and overflow_count to 0, without waiting for a clock edge.
REQ-026 FIFO storage SHALL NOT be reset, and m_axis_tdata is don't-care while m_axis_tvalid=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words; the first write after deassertion SHALL be read out first.

Configuration
REQ-028 Macro AXIS_SAMPLE_FIFO_OVF_CNT_EN SHALL control the overflow counter.
REQ-029 With AXIS_SAMPLE_FIFO_OVF_CNT_EN defined, overflow_count SHALL increment by 1 on each dropped sample, saturate at 16'hFFFF, and clear to 0 on clr_overflow=1; if clr_overflow and a drop occur in the same cycle, the count SHALL become 0.
REQ-030 Without AXIS_SAMPLE_FIFO_OVF_CNT_EN, overflow_count SHALL be tied to 0 and clr_overflow ignored; the port list is identical in both builds, and the overflow pulse is always present.

Verification
REQ-031 Scenario: DEPTH=16, m_axis_tready=0, write 0x1..0x10 -> fifo_level=16, overflow never pulses; then tready=1 -> output 0x1..0x10 in order, level returns to 0.
REQ-032 Scenario: full FIFO, tready=0, 3 further valid samples -> 3 overflow pulses, overflow_count=3 (macro on) or 0 (macro off), contents unchanged.
REQ-033 Scenario: full FIFO, tready=1 and s_axis_tvalid=1 for 20 cycles -> no overflow, level stays 16, data order preserved.
REQ-034 Scenario: empty FIFO, single write 0xA5A5A5A5 at edge N -> m_axis_tvalid=1 with that data after edge N and not before.
REQ-035 Scenario: 5 words buffered, s_axis_aresetn pulsed low between edges -> level=0 and m_axis_tvalid=0 immediately; next write 0x42 is the first word out.
REQ-036 Scenario (macro on): force 65540 drops -> overflow_count=0xFFFF; then clr_overflow=1 with a simultaneous drop -> overflow_count=0.
